// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with write-to-read bypass and a per-register pending scoreboard.
module register_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*XLEN-1:0]  rd,
  output logic [NREAD-1:0]       busy,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wa,
  input  logic [NWRITE*XLEN-1:0] wd,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr
);
  localparam logic [AW:0] NR = (AW+1)'(NREGS);
  logic [XLEN-1:0] r_mem [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend;
  logic [AW-1:0] w_wa [NWRITE];
  logic [XLEN-1:0] w_wd [NWRITE];
  // x0 and addresses past the end of the array never hold state
  function automatic logic f_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NR);
  endfunction
  for (genvar j = 0; j < NWRITE; j++) begin : g_wr
    assign w_wa[j] = wa[j*AW +: AW];
    assign w_wd[j] = wd[j*XLEN +: XLEN];
  end
  // later ports are visited last, so the highest-index writer wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) r_mem[k] <= '0;
      r_pend <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++)
        if (we[j] && f_ok(w_wa[j])) r_mem[w_wa[j]] <= w_wd[j];
      r_pend <= w_pend;
    end
  end
  // a same-cycle issue supersedes the retiring write's clear
  always_comb begin
    w_pend = r_pend;
    for (int j = 0; j < NWRITE; j++)
      if (we[j] && f_ok(w_wa[j])) w_pend[w_wa[j]] = 1'b0;
    if (iss_en && f_ok(iss_addr)) w_pend[iss_addr] = 1'b1;
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] w_a;
    logic w_hit;
    logic [XLEN-1:0] w_byp;
    assign w_a = ra[i*AW +: AW];
    always_comb begin
      w_hit = 1'b0;
      w_byp = '0;
      for (int j = 0; j < NWRITE; j++)
        if (BYPASS != 0 && we[j] && w_wa[j] == w_a) begin
          w_hit = 1'b1;
          w_byp = w_wd[j];
        end
    end
    assign rd[i*XLEN +: XLEN] = !f_ok(w_a) ? '0 : w_hit ? w_byp : r_mem[w_a];
    assign busy[i] = f_ok(w_a) && r_pend[w_a] && !w_hit;
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: table-driven scoreboard bench running BYPASS=1 and BYPASS=0 instances side by side.
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] ra;
  logic [1:0] we;
  logic [9:0] wa;
  logic [63:0] wd;
  logic iss_en;
  logic [4:0] iss_addr;
  logic [63:0] rd_b, rd_n;
  logic [1:0] busy_b, busy_n;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  register_file_mp #(.BYPASS(1)) u_b (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .busy(busy_b), .we(we), .wa(wa), .wd(wd),
    .iss_en(iss_en), .iss_addr(iss_addr));
  register_file_mp #(.BYPASS(0)) u_n (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .busy(busy_n), .we(we), .wa(wa), .wd(wd),
    .iss_en(iss_en), .iss_addr(iss_addr));
  typedef struct {
    logic rst; logic [1:0] we; logic [4:0] wa0, wa1; logic [31:0] wd0, wd1;
    logic ie; logic [4:0] ia, ra0, ra1;
    logic [31:0] b_rd0, b_rd1; logic [1:0] b_busy;
    logic [31:0] n_rd0, n_rd1; logic [1:0] n_busy;
  } vec_t;
  typedef struct { string name; logic [31:0] b_rd0, b_rd1; logic [1:0] b_busy; logic [31:0] n_rd0, n_rd1; logic [1:0] n_busy; } exp_t;
  exp_t q[$];
  vec_t vt[22];
  function automatic vec_t mk(logic r, logic [1:0] w, logic [4:0] a0, a1, logic [31:0] d0, d1,
                              logic e, logic [4:0] ea, r0, r1,
                              logic [31:0] br0, br1, logic [1:0] bb, logic [31:0] nr0, nr1, logic [1:0] nb);
    vec_t v;
    v.rst = r; v.we = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1; v.ie = e; v.ia = ea;
    v.ra0 = r0; v.ra1 = r1; v.b_rd0 = br0; v.b_rd1 = br1; v.b_busy = bb;
    v.n_rd0 = nr0; v.n_rd1 = nr1; v.n_busy = nb;
    return v;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic apply(string nm, vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.rst; we = v.we; wa = {v.wa1, v.wa0}; wd = {v.wd1, v.wd0};
    iss_en = v.ie; iss_addr = v.ia; ra = {v.ra1, v.ra0};
    e.name = nm; e.b_rd0 = v.b_rd0; e.b_rd1 = v.b_rd1; e.b_busy = v.b_busy;
    e.n_rd0 = v.n_rd0; e.n_rd1 = v.n_rd1; e.n_busy = v.n_busy;
    q.push_back(e);
    @(negedge clk);
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = q.pop_front();
      chk({e.name, " byp rd0"}, rd_b[31:0], e.b_rd0);
      chk({e.name, " byp rd1"}, rd_b[63:32], e.b_rd1);
      chk({e.name, " byp busy"}, {30'd0, busy_b}, {30'd0, e.b_busy});
      chk({e.name, " nobyp rd0"}, rd_n[31:0], e.n_rd0);
      chk({e.name, " nobyp rd1"}, rd_n[63:32], e.n_rd1);
      chk({e.name, " nobyp busy"}, {30'd0, busy_n}, {30'd0, e.n_busy});
    end
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; we = '0; wa = '0; wd = '0; iss_en = 1'b0; iss_addr = '0; ra = '0;
    repeat (2) @(posedge clk);
    vt[0]  = mk(0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0, 5, 6, 32'hDEADBEEF, 0, 2'b00, 0, 0, 2'b00);
    vt[1]  = mk(1, 2'b01, 6, 0, 32'h12345678, 0, 0, 0, 5, 6, 32'hDEADBEEF, 32'h12345678, 2'b00, 32'hDEADBEEF, 0, 2'b00);
    vt[2]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 2'b00, 0, 0, 2'b00);
    vt[3]  = mk(0, 2'b01, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    vt[4]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    vt[5]  = mk(0, 2'b11, 7, 7, 32'h11111111, 32'h22222222, 0, 0, 7, 0, 32'h22222222, 0, 2'b00, 0, 0, 2'b00);
    vt[6]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 32'h22222222, 0, 2'b00, 32'h22222222, 0, 2'b00);
    vt[7]  = mk(0, 2'b01, 3, 0, 32'hAB, 0, 0, 0, 3, 7, 32'hAB, 32'h22222222, 2'b00, 0, 32'h22222222, 2'b00);
    vt[8]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 7, 32'hAB, 32'h22222222, 2'b00, 32'hAB, 32'h22222222, 2'b00);
    vt[9]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 3, 0, 32'hAB, 2'b00, 0, 32'hAB, 2'b00);
    vt[10] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 3, 0, 32'hAB, 2'b01, 0, 32'hAB, 2'b01);
    vt[11] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 2'b01, 0, 0, 2'b01);
    vt[12] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 2'b01, 0, 0, 2'b01);
    vt[13] = mk(0, 2'b10, 0, 9, 0, 32'h99, 0, 0, 9, 9, 32'h99, 32'h99, 2'b00, 0, 0, 2'b11);
    vt[14] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 32'h99, 32'h99, 2'b00, 32'h99, 32'h99, 2'b00);
    vt[15] = mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0, 32'h99, 0, 2'b00, 32'h99, 0, 2'b00);
    vt[16] = mk(0, 2'b01, 9, 0, 32'h55, 0, 1, 9, 9, 9, 32'h55, 32'h55, 2'b00, 32'h99, 32'h99, 2'b11);
    vt[17] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 32'h55, 32'h55, 2'b11, 32'h55, 32'h55, 2'b11);
    vt[18] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 32'h55, 32'h55, 2'b11, 32'h55, 32'h55, 2'b11);
    vt[19] = mk(0, 2'b01, 9, 0, 32'h66, 0, 0, 0, 9, 9, 32'h66, 32'h66, 2'b00, 32'h55, 32'h55, 2'b11);
    vt[20] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 32'h66, 32'h66, 2'b00, 32'h66, 32'h66, 2'b00);
    vt[21] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 3, 32'h22222222, 32'hAB, 2'b00, 32'h22222222, 32'hAB, 2'b00);
    for (int i = 0; i < 22; i++) apply($sformatf("vec%0d", i), vt[i]);
    // pending x10 retired by a dual-port write to the same register
    apply("dual_iss", mk(0, 2'b00, 0, 0, 0, 0, 1, 10, 10, 10, 0, 0, 2'b00, 0, 0, 2'b00));
    apply("dual_wr", mk(0, 2'b11, 10, 10, 32'hA1, 32'hB2, 0, 0, 10, 10, 32'hB2, 32'hB2, 2'b00, 0, 0, 2'b11));
    apply("dual_after", mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 10, 10, 32'hB2, 32'hB2, 2'b00, 32'hB2, 32'hB2, 2'b00));
    // reset clears pending bits and overrides a same-cycle issue
    apply("rst_iss", mk(0, 2'b00, 0, 0, 0, 0, 1, 12, 12, 13, 0, 0, 2'b00, 0, 0, 2'b00));
    apply("rst_hit", mk(1, 2'b00, 0, 0, 0, 0, 1, 13, 12, 13, 0, 0, 2'b01, 0, 0, 2'b01));
    apply("rst_after", mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 12, 13, 0, 0, 2'b00, 0, 0, 2'b00));
    apply("rst_data", mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 10, 9, 0, 0, 2'b00, 0, 0, 2'b00));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core; successor to the single-write, two-read file.
- Adds configurable depth, width and port counts, synchronous clear, and a write-to-read bypass.
- Adds a per-register pending scoreboard so the issue stage can stall on an outstanding producer.
- Sits between decode/issue (read ports, issue marking) and writeback (write ports).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; address width AW = $clog2(NREGS)
NREAD, 2, number of read ports
NWRITE, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy; 0 = reads see storage only

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset
ra  input  NREAD*AW  read addresses; port i at [i*AW +: AW]
rd  output  NREAD*XLEN  read data; port i at [i*XLEN +: XLEN]
busy  output  NREAD  port i address has an outstanding producer
we  input  NWRITE  write enables
wa  input  NWRITE*AW  write addresses; port j at [j*AW +: AW]
wd  input  NWRITE*XLEN  write data; port j at [j*XLEN +: XLEN]
iss_en  input  1  issue of an instruction with a destination register
iss_addr  input  AW  destination register of the issuing instruction

Interface timing: one clock; reset is synchronous and active-high.

Behaviour:
- State: NREGS x XLEN storage array plus an NREGS-bit pending vector.
- Reset: at a rising clk edge with rst=1, all registers clear to 0 and all pending bits clear.
  - rst overrides any write or issue in the same cycle.
  - Outputs are combinational: after reset, rd = 0 and busy = 0 for every address.
- Register 0: always reads 0; writes to it are ignored; its pending bit is never set.
  - busy for address 0 is always 0.
- Out-of-range addresses (address >= NREGS, possible when NREGS is not a power of two): reads return 0, busy = 0, writes and issues are ignored.
- Write: at a rising edge, each port j with we[j]=1 and a valid nonzero wa_j loads wd_j.
  - Two or more ports targeting the same address in one cycle: the highest-index port wins.
- Read: combinational, zero added latency.
  - BYPASS=1: if any enabled write port targets ra_i (nonzero) this cycle, rd_i = wd of the highest-index such port; otherwise rd_i = storage.
  - BYPASS=0: rd_i = storage; the written value is visible on the cycle after the write edge.
- Pending update at a rising edge, evaluated in this order:
  - Any enabled write to address a clears pending[a].
  - iss_en=1 with a nonzero valid iss_addr sets pending[iss_addr].
  - Issue and write to the same address in the same cycle: pending ends SET, because a new producer supersedes the retiring one.
- busy_i = pending[ra_i] AND NOT (BYPASS AND an enabled write targets ra_i this cycle).
- No other state; no handshake back-pressure; no X output when all inputs are known.

Test Plan:
- Reset check: write 0xDEAD_BEEF to x5, then assert rst for 1 cycle with we[0]=1 to x6 in the same cycle -> x5 and x6 both read 0; busy all 0.
- Hardwired zero: we[0]=1, wa=0, wd=0xFFFF_FFFF; iss_en to x0 -> ra=0 reads 0 and busy=0 on every cycle.
- Write conflict: we=2'b11, wa0=wa1=x7, wd0=0x1111_1111, wd1=0x2222_2222 -> x7 holds 0x2222_2222 next cycle; with BYPASS=1, rd on ra=x7 shows 0x2222_2222 in the same cycle.
- Bypass off: BYPASS=0, write 0x0000_00AB to x3 while ra0=x3 -> rd0 shows the old value that cycle and 0xAB the next cycle.
- Scoreboard: iss_en to x9 at cycle 0 -> busy=1 from cycle 1 on ra=x9; write to x9 at cycle 4 -> busy=0 in cycle 4 (BYPASS=1), or from cycle 5 (BYPASS=0).
- Issue/write collision: x9 pending; in one cycle write x9=0x55 and iss_en x9 -> next cycle rd=0x55 and busy stays 1 until the following write to x9.
